// File: rtl/bus_peripherals.sv
// Memory-mapped peripheral block: a GPIO output port, a synchronised push-button,
// a free-running 32-bit timer with a sticky wrap flag, and an 8N1 UART transmitter.
// One access is taken per rising edge of bus_enable; data_ready acknowledges it.
module bus_peripherals #(
  parameter logic [15:0] BASE    = 16'h8000,
  parameter int          DIVISOR = 104
) (
  input  logic        raw_clk,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_mask,
  input  logic        bus_enable,
  input  logic        write_enable,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic [3:0]  ioport,
  input  logic        button_0,
  output logic        uart_tx_0
);

  localparam int             CNT_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  localparam logic [5:0] R_IOPORT  = 6'd0;
  localparam logic [5:0] R_BUTTON  = 6'd1;
  localparam logic [5:0] R_TIMER   = 6'd2;
  localparam logic [5:0] R_CTRL    = 6'd3;
  localparam logic [5:0] R_UART_TX = 6'd4;
  localparam logic [5:0] R_STATUS  = 6'd5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Bus front end
  logic        bus_en_q, seen_low_q, acc_q, data_ready_q;
  logic        acc_start, hit, wr_hit, rd_hit;
  logic [5:0]  reg_idx;
  logic [3:0]  lane_we;
  logic        unused_addr_lsb;

  // Peripheral state
  logic        btn_s1_q, btn_s2_q;
  logic [3:0]  ioport_q, ioport_d;
  logic [31:0] timer_q, timer_d, timer_inc;
  logic        enable_q, enable_d, wrap_q, wrap_d, wrap_set, ctrl_wr;
  logic        dropped_q, dropped_d;
  logic [31:0] data_out_q, data_out_d, rd_data;

  // UART transmitter
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy, bit_end, tx_wr, tx_accept, tx_drop, status_rd;

  // An access starts only on a low-to-high bus_enable seen after at least one low sample,
  // so a request already pending when reset lifts is ignored.
  assign acc_start = bus_enable & ~bus_en_q & seen_low_q;
  assign hit       = (address[15:8] == BASE[15:8]);
  assign wr_hit    = acc_start & write_enable & hit;
  assign rd_hit    = acc_start & ~write_enable & hit;
  assign reg_idx   = address[7:2];
  assign lane_we   = ~write_mask;
  assign unused_addr_lsb = ^address[1:0];

  assign busy      = (state_q != S_IDLE);
  assign bit_end   = (cnt_q == CNT_LAST);
  assign tx_wr     = wr_hit & (reg_idx == R_UART_TX) & lane_we[0];
  assign tx_accept = tx_wr & ~busy;
  assign tx_drop   = tx_wr & busy;
  assign status_rd = rd_hit & (reg_idx == R_STATUS);
  assign ctrl_wr   = wr_hit & (reg_idx == R_CTRL) & lane_we[0];
  assign wrap_set  = enable_q & (timer_q == 32'hFFFF_FFFF);

  // Edge detection and the data_ready handshake
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_en_q     <= 1'b0;
      seen_low_q   <= 1'b0;
      acc_q        <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      bus_en_q     <= bus_enable;
      seen_low_q   <= seen_low_q | ~bus_enable;
      acc_q        <= bus_enable & (acc_q | acc_start);
      data_ready_q <= bus_enable & acc_q;
    end
  end

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= button_0;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Next-state for IOPORT, TIMER, TIMER_CTRL and the dropped flag; written lanes beat the increment,
  // and a wrap beats a simultaneous write-1-to-clear
  always_comb begin
    ioport_d  = ioport_q;
    if (wr_hit && (reg_idx == R_IOPORT) && lane_we[0]) ioport_d = data_in[3:0];
    timer_inc = enable_q ? timer_q + 32'd1 : timer_q;
    timer_d   = timer_inc;
    if (wr_hit && (reg_idx == R_TIMER)) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) timer_d[8*i +: 8] = data_in[8*i +: 8];
      end
    end
    enable_d  = ctrl_wr ? data_in[0] : enable_q;
    wrap_d    = wrap_set | (wrap_q & ~(ctrl_wr & data_in[1]));
    dropped_d = tx_drop | (dropped_q & ~status_rd);
  end

  // Register file state
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      ioport_q  <= 4'd0;
      timer_q   <= 32'd0;
      enable_q  <= 1'b0;
      wrap_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      ioport_q  <= ioport_d;
      timer_q   <= timer_d;
      enable_q  <= enable_d;
      wrap_q    <= wrap_d;
      dropped_q <= dropped_d;
    end
  end

  // UART frame sequencing: START, eight data bits LSB first, STOP, each DIVISOR cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        if (tx_accept) begin
          state_d = S_START;
          cnt_d   = '0;
          shift_d = data_in[7:0];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // UART state registers; reset forces the line idle-high and abandons any frame
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Read mux; anything not listed reads as zero
  always_comb begin
    rd_data = 32'd0;
    case (reg_idx)
      R_IOPORT: rd_data = {28'd0, ioport_q};
      R_BUTTON: rd_data = {31'd0, btn_s2_q};
      R_TIMER:  rd_data = timer_q;
      R_CTRL:   rd_data = {30'd0, wrap_q, enable_q};
      R_STATUS: rd_data = {30'd0, dropped_q | tx_drop, busy};
      default:  rd_data = 32'd0;
    endcase
    data_out_d = rd_hit ? rd_data : data_out_q;
  end

  // Read data holds until the next read hit
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) data_out_q <= 32'd0;
    else          data_out_q <= data_out_d;
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign ioport     = ioport_q;
  assign uart_tx_0  = tx_q;

endmodule

// File: tb/tb_bus_peripherals.sv
// Randomised bench for bus_peripherals against a transaction-level reference model.
module tb_bus_peripherals;

  localparam int DIV = 4;

  logic        raw_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = 16'd0;
  logic [31:0] data_in = 32'd0;
  logic [3:0]  write_mask = 4'hF;
  logic        bus_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] data_out;
  logic        data_ready;
  logic [3:0]  ioport;
  logic        button_0 = 1'b0;
  logic        uart_tx_0;

  bus_peripherals #(.BASE(16'h8000), .DIVISOR(DIV)) dut (
    .raw_clk(raw_clk), .reset_n(reset_n), .address(address), .data_in(data_in),
    .write_mask(write_mask), .bus_enable(bus_enable), .write_enable(write_enable),
    .data_out(data_out), .data_ready(data_ready), .ioport(ioport),
    .button_0(button_0), .uart_tx_0(uart_tx_0)
  );

  always #5 raw_clk = ~raw_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state (cycle t = value right after the t-th rising edge)
  logic [3:0]  m_io = 4'd0;
  logic        m_btn = 1'b0;
  logic [31:0] m_dout = 32'd0;
  logic [31:0] tbase = 32'd0;
  int          tcyc = 0;
  logic        ten = 1'b0;
  logic        m_wrap = 1'b0;
  logic        m_drop = 1'b0;
  logic        u_act = 1'b0;
  int          u_a = 0;
  logic [7:0]  u_dat = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic u_busy(input int t);
    return u_act && (t >= u_a) && (t < u_a + 10 * DIV);
  endfunction

  function automatic logic u_tx(input int t);
    int k;
    if (!u_busy(t)) return 1'b1;
    k = (t - u_a) / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return u_dat[k-1];
  endfunction

  // Bring the timer model forward so tbase is the value after edge w
  task automatic advance(input int w);
    longint unsigned s;
    if (w > tcyc) begin
      if (ten) begin
        s = {32'd0, tbase} + 64'(w - tcyc);
        if (s > 64'h0000_0000_FFFF_FFFF) m_wrap = 1'b1;
        tbase = s[31:0];
      end
      tcyc = w;
    end
  endtask

  task automatic model_reset();
    tbase = 32'd0; tcyc = cyc; ten = 1'b0; m_wrap = 1'b0; m_drop = 1'b0;
    u_act = 1'b0; m_io = 4'd0; m_dout = 32'd0;
  endtask

  task automatic model_access(input int w, input logic [15:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic we);
    logic [5:0]  idx;
    logic [31:0] prev, nv;
    logic        wn;
    idx = a[7:2];
    if (a[15:8] != 8'h80) return;
    if (we) begin
      case (idx)
        6'd0: if (!m[0]) m_io = d[3:0];
        6'd2: begin
          advance(w - 1);
          wn   = ten && (tbase == 32'hFFFF_FFFF);
          prev = ten ? tbase + 32'd1 : tbase;
          for (int i = 0; i < 4; i++) nv[8*i +: 8] = m[i] ? prev[8*i +: 8] : d[8*i +: 8];
          tbase = nv; tcyc = w;
          if (wn) m_wrap = 1'b1;
        end
        6'd3: if (!m[0]) begin
          advance(w - 1);
          wn = ten && (tbase == 32'hFFFF_FFFF);
          if (ten) tbase = tbase + 32'd1;
          tcyc = w;
          if (d[1]) m_wrap = 1'b0;
          if (wn) m_wrap = 1'b1;
          ten = d[0];
        end
        6'd4: if (!m[0]) begin
          if (u_busy(w - 1)) m_drop = 1'b1;
          else begin u_act = 1'b1; u_a = w; u_dat = d[7:0]; end
        end
        default: ;
      endcase
    end else begin
      case (idx)
        6'd0: m_dout = {28'd0, m_io};
        6'd1: m_dout = {31'd0, m_btn};
        6'd2: begin advance(w - 1); m_dout = tbase; end
        6'd3: begin advance(w - 1); m_dout = {30'd0, m_wrap, ten}; end
        6'd5: begin m_dout = {30'd0, m_drop, u_busy(w - 1)}; m_drop = 1'b0; end
        default: m_dout = 32'd0;
      endcase
    end
  endtask

  task automatic step();
    @(negedge raw_clk);
    cyc++;
    check("uart_tx", {31'd0, uart_tx_0}, {31'd0, u_tx(cyc)});
    check("ioport", {28'd0, ioport}, {28'd0, m_io});
  endtask

  task automatic access(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic we, input int hold);
    address = a; data_in = d; write_mask = m; write_enable = we; bus_enable = 1'b1;
    model_access(cyc + 1, a, d, m, we);
    step();
    check("ready_first", {31'd0, data_ready}, 32'd0);
    for (int i = 1; i < hold; i++) begin
      step();
      check("ready_hold", {31'd0, data_ready}, 32'd1);
    end
    bus_enable = 1'b0;
    step();
    check("ready_drop", {31'd0, data_ready}, 32'd0);
    check("data_out", data_out, m_dout);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  logic [15:0] ra;
  logic [31:0] rd;
  logic [3:0]  rm;
  logic        rwe;
  int          rr, rix, rhold;

  initial begin
    repeat (3) @(negedge raw_clk);
    check("rst_tx", {31'd0, uart_tx_0}, 32'd1);
    check("rst_dout", data_out, 32'd0);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_io", {28'd0, ioport}, 32'd0);
    reset_n = 1'b1;
    model_reset();
    repeat (2) step();

    // GPIO write held for eight cycles
    access(16'h8000, 32'h0000_000A, 4'b1110, 1'b1, 8);
    check("io_A", {28'd0, ioport}, 32'hA);

    // Timer wrap and write-1-to-clear
    access(16'h8008, 32'hFFFF_FFFE, 4'b0000, 1'b1, 2);
    access(16'h800C, 32'h0000_0001, 4'b0000, 1'b1, 2);
    access(16'h8008, 32'h0, 4'b0000, 1'b0, 2);
    check("timer_wrapped", data_out, 32'h0);
    access(16'h800C, 32'h0, 4'b0000, 1'b0, 2);
    check("ctrl_wrap", data_out, 32'h3);
    access(16'h800C, 32'h0000_0003, 4'b0000, 1'b1, 2);
    access(16'h800C, 32'h0, 4'b0000, 1'b0, 2);
    check("ctrl_cleared", data_out, 32'h1);

    // UART frame, a dropped overlapping write, and status
    access(16'h8010, 32'h0000_0055, 4'b1110, 1'b1, 8);
    access(16'h8010, 32'h0000_00FF, 4'b0000, 1'b1, 2);
    access(16'h8014, 32'h0, 4'b0000, 1'b0, 2);
    check("status_drop", data_out, 32'h3);
    access(16'h8014, 32'h0, 4'b0000, 1'b0, 2);
    check("status_busy", data_out, 32'h1);
    repeat (40) step();
    access(16'h8014, 32'h0, 4'b0000, 1'b0, 2);
    check("status_idle", data_out, 32'h0);
    access(16'h8010, 32'h0000_0012, 4'b0001, 1'b1, 2);
    access(16'h8014, 32'h0, 4'b0000, 1'b0, 2);
    check("masked_tx", data_out, 32'h0);

    // Button then a decode miss
    button_0 = 1'b1; m_btn = 1'b1;
    repeat (4) step();
    access(16'h8004, 32'h0, 4'b0000, 1'b0, 2);
    check("button", data_out, 32'h1);
    access(16'h7F00, 32'h0, 4'b0000, 1'b0, 3);
    check("miss_hold", data_out, 32'h1);
    access(16'h8018, 32'h0, 4'b0000, 1'b0, 2);
    check("unmapped", data_out, 32'h0);

    // Randomised traffic
    for (int n = 0; n < 250; n++) begin
      rr = int'($urandom_range(0, 99));
      if (rr < 5) begin
        button_0 = ~button_0; m_btn = button_0;
        repeat (3) step();
      end
      rix = int'($urandom_range(0, 9));
      ra[15:8] = 8'h80;
      ra[7:2]  = 6'(rix);
      ra[1:0]  = 2'($urandom_range(0, 3));
      if (rr >= 5 && rr < 15) begin
        ra[15:8] = 8'($urandom_range(0, 255));
        if (ra[15:8] == 8'h80) ra[15:8] = 8'h7F;
      end
      rd = $urandom;
      if (rix == 2 && (rr % 3) == 0) rd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      rm    = 4'($urandom_range(0, 15));
      rwe   = 1'($urandom_range(0, 1));
      rhold = int'($urandom_range(2, 5));
      access(ra, rd, rm, rwe, rhold);
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset in the middle of a frame, with a request already pending
    repeat (45) step();
    access(16'h8010, 32'h0000_00A5, 4'b0000, 1'b1, 2);
    repeat (5) step();
    address = 16'h8000; data_in = 32'h0000_000F; write_mask = 4'b0000;
    write_enable = 1'b1; bus_enable = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_tx", {31'd0, uart_tx_0}, 32'd1);
    check("midrst_dout", data_out, 32'd0);
    check("midrst_ready", {31'd0, data_ready}, 32'd0);
    check("midrst_io", {28'd0, ioport}, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_access_ready", {31'd0, data_ready}, 32'd0);
    end
    bus_enable = 1'b0;
    step();
    access(16'h8008, 32'h0, 4'b0000, 1'b0, 2);
    check("rst_timer", data_out, 32'h0);
    access(16'h800C, 32'h0, 4'b0000, 1'b0, 2);
    check("rst_ctrl", data_out, 32'h0);
    access(16'h8014, 32'h0, 4'b0000, 1'b0, 2);
    check("rst_status", data_out, 32'h0);
    access(16'h8000, 32'h0, 4'b0000, 1'b0, 2);
    check("rst_ioport_reg", data_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
